// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//
// Bundles the fetch-side lookup and the EX-side training/redirect signals of the
// dynamic branch predictor.
//
//   master : the pipeline. It drives the fetch PC and the resolved-branch
//            update, and receives the prediction and the flush/redirect.
//   slave  : the predictor itself.
//
// Signals
//   i_pc_F           current fetch PC
//   o_pred_taken     prediction for i_pc_F (1 = taken)
//   o_pred_target    predicted target, 0 when not taken
//   i_upd_en         EX holds a resolved branch or jump this cycle
//   i_upd_pc         PC of the resolved instruction
//   i_upd_is_jump    resolved instruction is JAL/JALR
//   i_upd_taken      actual outcome
//   i_upd_target     actual target
//   i_pred_taken_E   prediction that travelled with the instruction
//   i_pred_target_E  predicted target that travelled with the instruction
//   o_flush          flush IF/ID and ID/EX, redirect fetch
//   o_redirect_pc    correct next PC when o_flush = 1, else 0
//   o_br_count       resolved updates since reset
//   o_miss_count     mispredictions since reset
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
   parameter int PC_W = 32
);
   logic [PC_W-1:0] i_pc_F;
   logic            o_pred_taken;
   logic [PC_W-1:0] o_pred_target;
   logic            i_upd_en;
   logic [PC_W-1:0] i_upd_pc;
   logic            i_upd_is_jump;
   logic            i_upd_taken;
   logic [PC_W-1:0] i_upd_target;
   logic            i_pred_taken_E;
   logic [PC_W-1:0] i_pred_target_E;
   logic            o_flush;
   logic [PC_W-1:0] o_redirect_pc;
   logic [31:0]     o_br_count;
   logic [31:0]     o_miss_count;

   modport master (
      output i_pc_F, i_upd_en, i_upd_pc, i_upd_is_jump, i_upd_taken,
             i_upd_target, i_pred_taken_E, i_pred_target_E,
      input  o_pred_taken, o_pred_target, o_flush, o_redirect_pc,
             o_br_count, o_miss_count
   );

   modport slave (
      input  i_pc_F, i_upd_en, i_upd_pc, i_upd_is_jump, i_upd_taken,
             i_upd_target, i_pred_taken_E, i_pred_target_E,
      output o_pred_taken, o_pred_target, o_flush, o_redirect_pc,
             o_br_count, o_miss_count
   );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage dynamic branch predictor: a direct-mapped BTB whose entries hold
// valid, tag, target and a 2-bit saturating counter. Lookup is combinational on
// the fetch PC. Resolved branches/jumps from EX train the table on the rising
// edge and raise a flush plus the correct next PC on a misprediction.
//
// Ports
//   i_clk  system clock, all state changes on the rising edge
//   i_rst  synchronous reset, active-high; clears training and counters and
//          forces the prediction and flush/redirect outputs to 0
//   bus    branch_predictor_if.slave, lookup / update / redirect / counters
//
// Address split: idx = pc[IW+1:2], tag = pc[PC_W-1:IW+2], pc[1:0] ignored.
// A lookup and an update in the same cycle at one index see the pre-update
// entry; there is no bypass.
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int BTB_ENTRIES = 16,
   parameter int PC_W        = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   branch_predictor_if.slave bus
);

   localparam int IW    = $clog2(BTB_ENTRIES);
   localparam int TAG_W = PC_W - IW - 2;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [1:0]       ctr;
   } entry_t;

   localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

   entry_t      entry_q [BTB_ENTRIES];
   logic [31:0] br_count_q,   br_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   // ---------------------------------------------------------------- lookup
   logic [IW-1:0]    lk_idx;
   logic [TAG_W-1:0] lk_tag;
   entry_t           lk_entry;
   logic             lk_taken;

   assign lk_idx   = bus.i_pc_F[IW+1:2];
   assign lk_tag   = bus.i_pc_F[PC_W-1:IW+2];
   assign lk_entry = entry_q[lk_idx];
   assign lk_taken = !i_rst && lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];

   assign bus.o_pred_taken  = lk_taken;
   assign bus.o_pred_target = lk_taken ? lk_entry.target : '0;

   // ----------------------------------------------------------- mispredict
   logic miss;
   logic flush;

   assign miss  = bus.i_upd_en &&
                  ((bus.i_upd_taken != bus.i_pred_taken_E) ||
                   (bus.i_upd_taken && (bus.i_upd_target != bus.i_pred_target_E)));
   assign flush = !i_rst && miss;

   assign bus.o_flush       = flush;
   assign bus.o_redirect_pc = !flush          ? '0 :
                              bus.i_upd_taken ? bus.i_upd_target :
                                                bus.i_upd_pc + PC_W'(4);

   // --------------------------------------------------------------- update
   logic [IW-1:0]    upd_idx;
   logic [TAG_W-1:0] upd_tag;
   entry_t           upd_entry;
   logic             upd_hit;
   entry_t           entry_d;
   logic             entry_we;

   assign upd_idx   = bus.i_upd_pc[IW+1:2];
   assign upd_tag   = bus.i_upd_pc[PC_W-1:IW+2];
   assign upd_entry = entry_q[upd_idx];
   assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      entry_d  = upd_entry;
      entry_we = 1'b0;
      if (bus.i_upd_en) begin
         if (upd_hit) begin
            entry_we = 1'b1;
            if (bus.i_upd_is_jump) begin
               entry_d.ctr    = 2'b11;
               entry_d.target = bus.i_upd_target;
            end else if (bus.i_upd_taken) begin
               entry_d.ctr    = (upd_entry.ctr == 2'b11) ? 2'b11 : upd_entry.ctr + 2'd1;
               entry_d.target = bus.i_upd_target;
            end else begin
               entry_d.ctr    = (upd_entry.ctr == 2'b00) ? 2'b00 : upd_entry.ctr - 2'd1;
            end
         end else if (bus.i_upd_taken) begin
            // Allocate on a taken miss, evicting whatever aliases to this index.
            entry_we       = 1'b1;
            entry_d.valid  = 1'b1;
            entry_d.tag    = upd_tag;
            entry_d.target = bus.i_upd_target;
            entry_d.ctr    = bus.i_upd_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

   assign br_count_d   = br_count_q   + 32'(bus.i_upd_en);
   assign miss_count_d = miss_count_q + 32'(miss);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before this edge, regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: the table is a flop array and is cleared on reset because
         // "reset discards all training" is architectural behaviour; a RAM
         // would need a clearing sequence instead.
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entry_q[i] <= ENTRY_RESET;
         end
         br_count_q   <= '0;
         miss_count_q <= '0;
      end else begin
         if (entry_we) begin
            entry_q[upd_idx] <= entry_d;
         end
         br_count_q   <= br_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign bus.o_br_count   = br_count_q;
   assign bus.o_miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor (BTB_ENTRIES = 16, PC_W = 32). A table of
// per-cycle vectors gives the inputs and the hand-computed outputs for that
// cycle (counters show the value before that cycle's edge). Hand-written
// sequences cover reset entry and counter saturation at 00.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predictor_if #(.PC_W(32)) bus ();

   branch_predictor #(
      .BTB_ENTRIES (16),
      .PC_W        (32)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] pc_f;
      logic        upd_en;
      logic [31:0] upd_pc;
      logic        jmp;
      logic        tkn;
      logic [31:0] tgt;
      logic        pte;
      logic [31:0] pge;
      logic        e_pt;
      logic [31:0] e_pg;
      logic        e_fl;
      logic [31:0] e_rd;
      logic [31:0] e_br;
      logic [31:0] e_mc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic r, input logic [31:0] pcf, input logic en, input logic [31:0] upc,
      input logic j, input logic t, input logic [31:0] tg, input logic pt_e,
      input logic [31:0] pg_e, input logic ept, input logic [31:0] epg,
      input logic efl, input logic [31:0] erd, input logic [31:0] ebr,
      input logic [31:0] emc);
      vec_t v;
      v.rst = r;    v.pc_f = pcf;  v.upd_en = en;  v.upd_pc = upc;
      v.jmp = j;    v.tkn = t;     v.tgt = tg;     v.pte = pt_e;  v.pge = pg_e;
      v.e_pt = ept; v.e_pg = epg;  v.e_fl = efl;   v.e_rd = erd;
      v.e_br = ebr; v.e_mc = emc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst                 = v.rst;
      bus.i_pc_F          = v.pc_f;
      bus.i_upd_en        = v.upd_en;
      bus.i_upd_pc        = v.upd_pc;
      bus.i_upd_is_jump   = v.jmp;
      bus.i_upd_taken     = v.tkn;
      bus.i_upd_target    = v.tgt;
      bus.i_pred_taken_E  = v.pte;
      bus.i_pred_target_E = v.pge;
   endtask

   // Hand-sequence helpers: an update is applied at the next rising edge.
   task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                      input logic pt_e, input logic [31:0] pg_e);
      @(posedge clk); #1;
      drive(mk(1'b0, pc, 1'b1, pc, 1'b0, t, tg, pt_e, pg_e, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic look(input string name, input logic [31:0] pc, input logic ept,
                       input logic [31:0] epg);
      @(posedge clk); #1;
      drive(mk(1'b0, pc, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check({name, " pred_taken"},  32'(bus.o_pred_taken), 32'(ept));
      check({name, " pred_target"}, bus.o_pred_target, epg);
   endtask

   initial begin
      // ---------------------------------------------------------- vector table
      // mk(rst, pc_F, upd_en, upd_pc, jump, taken, target, pred_taken_E, pred_target_E,
      //    exp_pred_taken, exp_pred_target, exp_flush, exp_redirect, exp_br, exp_miss)
      vq.push_back(mk(0, 32'h40, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  0,  0));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 1, 32'h020, 0, 32'h000, 0, 32'h000, 1, 32'h020,  0,  0));
      vq.push_back(mk(0, 32'h40, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 1, 32'h020, 0, 32'h000,  1,  1));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 0, 32'h000, 1, 32'h020, 1, 32'h020, 1, 32'h044,  1,  1));
      vq.push_back(mk(0, 32'h40, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  2,  2));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 1, 32'h020, 0, 32'h000, 0, 32'h000, 1, 32'h020,  2,  2));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 1, 32'h020, 1, 32'h020, 1, 32'h020, 0, 32'h000,  3,  3));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 1, 32'h020, 1, 32'h020, 1, 32'h020, 0, 32'h000,  4,  3));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 0, 32'h000, 1, 32'h020, 1, 32'h020, 1, 32'h044,  5,  3));
      vq.push_back(mk(0, 32'h40, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 1, 32'h020, 0, 32'h000,  6,  4));
      // aliasing: 0x80 shares index 0 with 0x40
      vq.push_back(mk(0, 32'h80, 1, 32'h80, 0, 1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 32'h100,  6,  4));
      vq.push_back(mk(0, 32'h40, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  7,  5));
      vq.push_back(mk(0, 32'h82, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 1, 32'h100, 0, 32'h000,  7,  5));
      // not-taken miss does not allocate
      vq.push_back(mk(0, 32'h48, 1, 32'h48, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  7,  5));
      vq.push_back(mk(0, 32'h48, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  8,  5));
      // jump with same-cycle lookup, correct prediction, wrong target
      vq.push_back(mk(0, 32'h10, 1, 32'h10, 1, 1, 32'h200, 0, 32'h000, 0, 32'h000, 1, 32'h200,  8,  5));
      vq.push_back(mk(0, 32'h10, 1, 32'h10, 1, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h000,  9,  6));
      vq.push_back(mk(0, 32'h10, 1, 32'h10, 1, 1, 32'h300, 1, 32'h200, 1, 32'h200, 1, 32'h300, 10,  6));
      vq.push_back(mk(0, 32'h10, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 1, 32'h300, 0, 32'h000, 11,  7));
      // fall-through redirect wraps mod 2^32
      vq.push_back(mk(0, 32'h10, 1, 32'hFFFF_FFFC, 0, 0, 32'h000, 1, 32'h000, 1, 32'h300, 1, 32'h000, 11, 7));
      // train more entries (0x80, 0x10, 0x44, 0x4C, 0x58 valid)
      vq.push_back(mk(0, 32'h44, 1, 32'h44, 0, 1, 32'h400, 0, 32'h000, 0, 32'h000, 1, 32'h400, 12,  8));
      vq.push_back(mk(0, 32'h44, 1, 32'h4C, 0, 1, 32'h500, 0, 32'h000, 1, 32'h400, 1, 32'h500, 13,  9));
      vq.push_back(mk(0, 32'h4C, 1, 32'h58, 1, 1, 32'h600, 0, 32'h000, 1, 32'h500, 1, 32'h600, 14, 10));
      // reset with a simultaneous update: outputs forced to 0
      vq.push_back(mk(1, 32'h80, 1, 32'h40, 0, 1, 32'h020, 0, 32'h000, 0, 32'h000, 0, 32'h000, 15, 11));
      vq.push_back(mk(0, 32'h80, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  0,  0));
      vq.push_back(mk(0, 32'h10, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  0,  0));
      vq.push_back(mk(0, 32'h44, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  0,  0));
      vq.push_back(mk(0, 32'h4C, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  0,  0));
      vq.push_back(mk(0, 32'h58, 0, 32'h00, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000,  0,  0));
      vq.push_back(mk(0, 32'h40, 1, 32'h40, 0, 1, 32'h020, 0, 32'h000, 0, 32'h000, 1, 32'h020,  0,  0));

      // ------------------------------------------------ initial reset sequence
      // Update asserted during reset: outputs must still read 0.
      drive(mk(1, 32'h40, 1, 32'h40, 0, 1, 32'h20, 0, 32'h0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("rst%0d pred_taken", c),  32'(bus.o_pred_taken), 32'd0);
         check($sformatf("rst%0d pred_target", c), bus.o_pred_target,     32'd0);
         check($sformatf("rst%0d flush", c),       32'(bus.o_flush),      32'd0);
         check($sformatf("rst%0d redirect", c),    bus.o_redirect_pc,     32'd0);
         @(posedge clk); #1;
      end

      // ------------------------------------------------------- table-driven
      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk); #1;
         drive(vq[i]);
         @(negedge clk);
         check($sformatf("row%0d pred_taken", i),  32'(bus.o_pred_taken), 32'(vq[i].e_pt));
         check($sformatf("row%0d pred_target", i), bus.o_pred_target,     vq[i].e_pg);
         check($sformatf("row%0d flush", i),       32'(bus.o_flush),      32'(vq[i].e_fl));
         check($sformatf("row%0d redirect", i),    bus.o_redirect_pc,     vq[i].e_rd);
         check($sformatf("row%0d br_count", i),    bus.o_br_count,        vq[i].e_br);
         check($sformatf("row%0d miss_count", i),  bus.o_miss_count,      vq[i].e_mc);
      end

      // ------------------------------------- counter saturation at 00 (hand)
      // Last table row allocated 0x40 with ctr 10 (br=1, miss=1).
      upd(32'h40, 1'b0, 32'h0,  1'b1, 32'h20);  // ctr 10 -> 01, mispredict
      upd(32'h40, 1'b0, 32'h0,  1'b0, 32'h00);  // 01 -> 00
      upd(32'h40, 1'b0, 32'h0,  1'b0, 32'h00);  // 00 holds
      upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h00);  // 00 -> 01, mispredict
      look("sat_lo", 32'h40, 1'b0, 32'h0);
      check("sat_lo br_count",   bus.o_br_count,   32'd5);
      check("sat_lo miss_count", bus.o_miss_count, 32'd3);
      upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h00);  // 01 -> 10, mispredict
      look("sat_up", 32'h40, 1'b1, 32'h20);
      check("sat_up br_count",   bus.o_br_count,   32'd6);
      check("sat_up miss_count", bus.o_miss_count, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the 5-stage RV32I pipeline; sits directly upstream of the IF/ID register and steers next-PC selection.
- Direct-mapped BTB with a 2-bit saturating counter per entry.
- Trained by resolved branches/jumps from EX; raises a flush/redirect on misprediction, replacing the current always-not-taken scheme.
- Keeps branch and mispredict counters for the bench.

Parameters:
- BTB_ENTRIES, 16: number of BTB entries; power of 2, 4 to 256. Index width is IW = log2(BTB_ENTRIES).
- PC_W, 32: PC and target width.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_pc_F  in  PC_W  current fetch PC.
- o_pred_taken  out  1  prediction for i_pc_F: 1 = taken.
- o_pred_target  out  PC_W  predicted target; 0 when o_pred_taken = 0.
- i_upd_en  in  1  EX holds a resolved branch or jump this cycle.
- i_upd_pc  in  PC_W  PC of the resolved instruction.
- i_upd_is_jump  in  1  resolved instruction is JAL/JALR.
- i_upd_taken  in  1  actual outcome (br_sel_final from EX).
- i_upd_target  in  PC_W  actual target (alu_data_E).
- i_pred_taken_E  in  1  prediction carried down the pipe with this instruction.
- i_pred_target_E  in  PC_W  predicted target carried down the pipe.
- o_flush  out  1  flush IF/ID and ID/EX; redirect fetch.
- o_redirect_pc  out  PC_W  correct next PC when o_flush = 1; 0 otherwise.
- o_br_count  out  32  resolved updates since reset.
- o_miss_count  out  32  mispredictions since reset.

Behaviour:
- Address split:
  - idx = pc[IW+1:2]
  - tag = pc[PC_W-1:IW+2]
  - pc[1:0] ignored
- Entry contents: valid, tag, target[PC_W], ctr[2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag matches.
  - o_pred_taken = hit && ctr[1].
  - o_pred_target = entry target when o_pred_taken = 1, else 0.
- Mispredict (combinational, valid only when i_upd_en = 1):
  - miss = (i_upd_taken != i_pred_taken_E) || (i_upd_taken && i_upd_target != i_pred_target_E).
  - o_flush = miss.
  - o_redirect_pc = i_upd_target if i_upd_taken, else i_upd_pc + 4 (mod 2^PC_W).
- Update on rising edge when i_upd_en = 1, using the entry at i_upd_pc:
  - Hit, branch:
    - taken: ctr saturating +1 (11 holds); target <= i_upd_target.
    - not taken: ctr saturating -1 (00 holds); target unchanged.
  - Hit, jump: ctr <= 11; target <= i_upd_target.
  - Miss and taken (branch or jump): allocate, overwriting any existing entry.
    - valid <= 1; tag <= upd tag; target <= i_upd_target.
    - ctr <= 11 for a jump, 10 for a branch.
  - Miss and not taken: no allocation; table unchanged.
  - o_br_count += 1. o_miss_count += 1 if miss. Both wrap at 2^32.
- Same-cycle lookup and update at one index: lookup returns pre-update contents; no bypass. The update is visible on the next cycle.
- Reset (i_rst = 1 at rising edge):
  - All valid <= 0; all ctr <= 01; targets and tags <= 0.
  - Both counters <= 0.
  - Reset wins over a simultaneous update.
- While i_rst = 1, o_pred_taken, o_pred_target, o_flush and o_redirect_pc are forced to 0.
- Reset mid-operation discards all training; the next cycle predicts not-taken everywhere.
- With i_upd_en = 0: o_flush = 0, o_redirect_pc = 0, no state change.
- Storage: flops; a register array is acceptable. No RAM inference required.

Test Plan:
- Reset, then lookup i_pc_F = 0x0000_0040 -> o_pred_taken = 0, o_pred_target = 0, o_br_count = 0, o_miss_count = 0.
- Update pc = 0x40, branch, taken, target 0x20, pred_taken_E = 0:
  - o_flush = 1 and o_redirect_pc = 0x20 in the same cycle.
  - Next cycle, lookup 0x40 -> taken, target 0x20, ctr = 10.
  - o_miss_count = 1.
- Same branch, three more updates:
  - Not-taken, pred_taken_E = 1 -> o_flush = 1, o_redirect_pc = 0x44, ctr = 01, lookup predicts not-taken.
  - Taken twice -> ctr 10 then 11; a further taken update holds at 11.
- Aliasing, BTB_ENTRIES = 16:
  - Train 0x40 taken to 0x20.
  - Update 0x80 taken to 0x100 (same idx 0, different tag).
  - Lookup 0x40 -> not taken; lookup 0x80 -> taken, target 0x100.
- Jump and same-cycle update:
  - JAL at 0x10, target 0x200 -> ctr 11.
  - Same-cycle lookup of 0x10 during that update -> old (not-taken) result.
  - Correct prediction with matching target -> o_flush = 0, o_miss_count unchanged.
- Assert i_rst for one cycle after training 5 entries, with i_upd_en = 1 in that cycle:
  - All lookups not-taken.
  - Both counters 0.
  - Outputs 0 during reset.
